// File: rtl/fft_frame_arbiter_if.sv
// rtl/fft_frame_arbiter_if.sv - requester and FFT-side stream signals of the frame arbiter
interface fft_frame_arbiter_if #(
   parameter int DW = 32
);
   logic [DW-1:0] asi_ch0_data;
   logic          asi_ch0_valid;
   logic          asi_ch0_ready;
   logic [DW-1:0] asi_ch1_data;
   logic          asi_ch1_valid;
   logic          asi_ch1_ready;
   logic [DW-1:0] aso_out_data;
   logic          aso_out_valid;
   logic          aso_out_startofpacket;
   logic          aso_out_endofpacket;
   logic          aso_out_inverse;
   logic          aso_out_channel;
   logic          aso_out_ready;
   logic          busy;

   modport master (
      input  asi_ch0_data, asi_ch0_valid, asi_ch1_data, asi_ch1_valid, aso_out_ready,
      output asi_ch0_ready, asi_ch1_ready, aso_out_data, aso_out_valid,
             aso_out_startofpacket, aso_out_endofpacket, aso_out_inverse,
             aso_out_channel, busy
   );

   modport slave (
      output asi_ch0_data, asi_ch0_valid, asi_ch1_data, asi_ch1_valid, aso_out_ready,
      input  asi_ch0_ready, asi_ch1_ready, aso_out_data, aso_out_valid,
             aso_out_startofpacket, aso_out_endofpacket, aso_out_inverse,
             aso_out_channel, busy
   );
endinterface

// File: rtl/fft_frame_arbiter.sv
// rtl/fft_frame_arbiter.sv - round-robin whole-frame arbiter feeding one FFT datapath
module fft_frame_arbiter #(
   parameter int INPUT_SYMBOL_WIDTH = 16,
   parameter int LOG2_FFT_LENGTH    = 10,
   parameter bit INVERSE_CH0        = 1'b0,
   parameter bit INVERSE_CH1        = 1'b1
) (
   input logic                 clock_clk,
   input logic                 reset_reset_n,
   fft_frame_arbiter_if.master bus
);
   localparam int DW = 2 * INPUT_SYMBOL_WIDTH;
   localparam logic [LOG2_FFT_LENGTH-1:0] LAST = '1;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_grant;
   logic                       r_prio;
   logic                       r_inv_tag;
   logic [LOG2_FFT_LENGTH-1:0] r_cnt;
   logic [DW-1:0]              r_data;
   logic                       r_valid;
   logic                       r_sop;
   logic                       r_eop;
   logic                       r_inv;
   logic                       r_chan;

   logic                       w_can_load;
   logic                       w_accept;
   logic                       w_last;
   logic                       w_arb_go;
   logic                       w_arb_ch;
   logic                       w_ready0;
   logic                       w_ready1;
   logic                       w_in_valid;
   logic [DW-1:0]              w_in_data;

   assign w_in_data = r_grant ? bus.asi_ch1_data : bus.asi_ch0_data;

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_arb_go    = 1'b0;
      w_arb_ch    = r_prio;
      w_can_load  = !r_valid || bus.aso_out_ready;
      w_ready0    = 1'b0;
      w_ready1    = 1'b0;
      w_in_valid  = r_grant ? bus.asi_ch1_valid : bus.asi_ch0_valid;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            // r_prio names the channel that wins a tie: the one not served last
            if (bus.asi_ch0_valid && bus.asi_ch1_valid) begin
               w_arb_go = 1'b1;
               w_arb_ch = r_prio;
            end else if (bus.asi_ch0_valid) begin
               w_arb_go = 1'b1;
               w_arb_ch = 1'b0;
            end else if (bus.asi_ch1_valid) begin
               w_arb_go = 1'b1;
               w_arb_ch = 1'b1;
            end
            if (w_arb_go) begin
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            w_ready0 = !r_grant && w_can_load;
            w_ready1 = r_grant && w_can_load;
            w_accept = w_in_valid && w_can_load;
            w_last   = w_accept && (r_cnt == LAST);
            if (w_last) begin
               w_state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_grant   <= 1'b0;
         r_prio    <= 1'b0;
         r_inv_tag <= 1'b0;
         r_cnt     <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_sop     <= 1'b0;
         r_eop     <= 1'b0;
         r_inv     <= 1'b0;
         r_chan    <= 1'b0;
      end else begin
         if (w_arb_go) begin
            r_grant   <= w_arb_ch;
            r_cnt     <= '0;
            r_inv_tag <= w_arb_ch ? INVERSE_CH1 : INVERSE_CH0;
         end
         if (w_accept) begin
            r_data  <= w_in_data;
            r_valid <= 1'b1;
            r_sop   <= (r_cnt == '0);
            r_eop   <= (r_cnt == LAST);
            r_inv   <= r_inv_tag;
            r_chan  <= r_grant;
            r_cnt   <= r_cnt + 1'b1;
         end else if (bus.aso_out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_last) begin
            r_prio <= ~r_grant;
         end
      end
   end

   assign bus.asi_ch0_ready         = w_ready0;
   assign bus.asi_ch1_ready         = w_ready1;
   assign bus.aso_out_data          = r_data;
   assign bus.aso_out_valid         = r_valid;
   assign bus.aso_out_startofpacket = r_sop;
   assign bus.aso_out_endofpacket   = r_eop;
   assign bus.aso_out_inverse       = r_inv;
   assign bus.aso_out_channel       = r_chan;
   assign bus.busy                  = (r_state == GRANT);
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// tb/tb_fft_frame_arbiter.sv - self-checking bench for fft_frame_arbiter
module tb_fft_frame_arbiter;
   localparam int W  = 16;
   localparam int L  = 3;
   localparam int N  = 8;
   localparam int DW = 2 * W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_frame_arbiter_if #(.DW(DW)) bus();

   fft_frame_arbiter #(
      .INPUT_SYMBOL_WIDTH(W),
      .LOG2_FFT_LENGTH(L),
      .INVERSE_CH0(1'b0),
      .INVERSE_CH1(1'b1)
   ) dut (
      .clock_clk(clk),
      .reset_reset_n(rst_n),
      .bus(bus.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // frame-level reference state
   bit          m_busy, m_ov, m_sop, m_eop, m_inv, m_ch;
   int          m_owner, m_pos, m_pref;
   logic [31:0] m_od;
   int          k[2];
   bit          v[2];
   bit          ordy;
   int          q_eop[$];

   typedef struct {
      bit          v0;
      bit          ordy;
      logic [31:0] d0;
      bit          e_r0;
      bit          e_busy;
      bit          e_ov;
      bit          e_sop;
      bit          e_eop;
      logic [31:0] e_data;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sample(input int c, input int idx);
      return (c == 1) ? (32'h8000_0000 | 32'(idx)) : 32'(idx);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ready0"}, 32'(bus.asi_ch0_ready), 32'd0);
      check({tag, "_ready1"}, 32'(bus.asi_ch1_ready), 32'd0);
      check({tag, "_valid"},  32'(bus.aso_out_valid), 32'd0);
      check({tag, "_data"},   bus.aso_out_data, 32'd0);
      check({tag, "_sop"},    32'(bus.aso_out_startofpacket), 32'd0);
      check({tag, "_eop"},    32'(bus.aso_out_endofpacket), 32'd0);
      check({tag, "_inv"},    32'(bus.aso_out_inverse), 32'd0);
      check({tag, "_chan"},   32'(bus.aso_out_channel), 32'd0);
      check({tag, "_busy"},   32'(bus.busy), 32'd0);
   endtask

   task automatic model_reset();
      m_busy = 0; m_ov = 0; m_sop = 0; m_eop = 0; m_inv = 0; m_ch = 0;
      m_owner = 0; m_pos = 0; m_pref = 0; m_od = '0;
   endtask

   task automatic step();
      bit r[2];
      bit acc;
      bit was_busy;
      bus.asi_ch0_valid = v[0];
      bus.asi_ch1_valid = v[1];
      bus.asi_ch0_data  = sample(0, k[0]);
      bus.asi_ch1_data  = sample(1, k[1]);
      bus.aso_out_ready = ordy;
      @(negedge clk);
      for (int c = 0; c < 2; c++) r[c] = m_busy && (m_owner == c) && (!m_ov || ordy);
      check("ready0", 32'(bus.asi_ch0_ready), 32'(r[0]));
      check("ready1", 32'(bus.asi_ch1_ready), 32'(r[1]));
      check("busy",   32'(bus.busy), 32'(m_busy));
      check("ovalid", 32'(bus.aso_out_valid), 32'(m_ov));
      if (m_ov) begin
         check("odata", bus.aso_out_data, m_od);
         check("osop",  32'(bus.aso_out_startofpacket), 32'(m_sop));
         check("oeop",  32'(bus.aso_out_endofpacket), 32'(m_eop));
         check("oinv",  32'(bus.aso_out_inverse), 32'(m_inv));
         check("ochan", 32'(bus.aso_out_channel), 32'(m_ch));
      end
      if (bus.aso_out_valid && bus.aso_out_ready && bus.aso_out_endofpacket)
         q_eop.push_back(int'(bus.aso_out_channel));
      @(posedge clk);
      was_busy = m_busy;
      acc = m_busy && v[m_owner] && r[m_owner];
      if (acc) begin
         m_ov  = 1;
         m_od  = sample(m_owner, k[m_owner]);
         m_sop = (m_pos == 0);
         m_eop = (m_pos == N - 1);
         m_inv = (m_owner == 1);
         m_ch  = m_owner[0];
         k[m_owner]++;
         m_pos++;
         if (m_pos == N) begin
            m_busy = 0;
            m_pref = 1 - m_owner;
         end
      end else if (ordy) begin
         m_ov = 0;
      end
      if (!was_busy && (v[0] || v[1])) begin
         m_owner = (v[0] && v[1]) ? m_pref : (v[0] ? 0 : 1);
         m_busy  = 1;
         m_pos   = 0;
      end
      #1;
   endtask

   task automatic do_reset(input bit check_async);
      rst_n = 1'b0;
      v[0] = 0; v[1] = 0;
      bus.asi_ch0_valid = 1'b0;
      bus.asi_ch1_valid = 1'b0;
      #1;
      if (check_async) check_all_zero("arst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int drop;
      bit pat[4];
      bus.asi_ch0_valid = 1'b0; bus.asi_ch1_valid = 1'b0;
      bus.asi_ch0_data  = '0;   bus.asi_ch1_data  = '0;
      bus.aso_out_ready = 1'b0;
      v[0] = 0; v[1] = 0; ordy = 0; k[0] = 0; k[1] = 0;
      model_reset();
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

      // single ch0 requester, ready high: 8 samples then one idle cycle
      for (int i = 0; i < 11; i++) begin
         tbl[i].v0     = 1;
         tbl[i].ordy   = 1;
         tbl[i].d0     = {16'(i), 16'(i)};
         tbl[i].e_busy = (i >= 1 && i <= 8) || (i == 10);
         tbl[i].e_r0   = tbl[i].e_busy;
         tbl[i].e_ov   = (i >= 2 && i <= 9);
         tbl[i].e_sop  = (i == 2);
         tbl[i].e_eop  = (i == 9);
         tbl[i].e_data = {16'(i - 1), 16'(i - 1)};
      end

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         bus.asi_ch0_valid = tbl[i].v0;
         bus.asi_ch0_data  = tbl[i].d0;
         bus.aso_out_ready = tbl[i].ordy;
         @(negedge clk);
         check("t_ready0", 32'(bus.asi_ch0_ready), 32'(tbl[i].e_r0));
         check("t_ready1", 32'(bus.asi_ch1_ready), 32'd0);
         check("t_busy",   32'(bus.busy), 32'(tbl[i].e_busy));
         check("t_valid",  32'(bus.aso_out_valid), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            check("t_data", bus.aso_out_data, tbl[i].e_data);
            check("t_sop",  32'(bus.aso_out_startofpacket), 32'(tbl[i].e_sop));
            check("t_eop",  32'(bus.aso_out_endofpacket), 32'(tbl[i].e_eop));
            check("t_inv",  32'(bus.aso_out_inverse), 32'd0);
            check("t_chan", 32'(bus.aso_out_channel), 32'd0);
         end
         @(posedge clk);
         #1;
      end

      // both requesters valid from reset: frames alternate ch0, ch1, ch0, ch1
      do_reset(0);
      q_eop.delete();
      v[0] = 1; v[1] = 1; ordy = 1;
      repeat (45) step();
      check("rr_frames", 32'(q_eop.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         if (i < q_eop.size()) check("rr_order", 32'(q_eop[i]), 32'(i % 2));

      // backpressure with ready pattern 1,0,0,1
      for (int c = 0; c < 64; c++) begin
         ordy = pat[c % 4];
         step();
      end

      // ch1 stalls mid-frame while ch0 waits
      do_reset(0);
      q_eop.delete();
      v[0] = 0; v[1] = 1; ordy = 1;
      step();
      v[0] = 1;
      base = k[1];
      drop = 0;
      for (int c = 0; c < 60 && q_eop.size() == 0; c++) begin
         if (k[1] - base >= 3 && drop < 5) begin
            v[1] = 0;
            drop++;
         end else begin
            v[1] = 1;
         end
         step();
      end
      check("stall_drop", 32'(drop), 32'd5);
      check("stall_done", 32'(q_eop.size() >= 1), 32'd1);
      if (q_eop.size() >= 1) check("stall_ch", 32'(q_eop[0]), 32'd1);

      // reset after the 4th sample of a ch0 frame
      do_reset(0);
      q_eop.delete();
      v[0] = 1; v[1] = 0; ordy = 1;
      base = k[0];
      for (int c = 0; c < 30 && (k[0] - base) < 4; c++) step();
      check("mid_reach", 32'(k[0] - base), 32'd4);
      check("mid_noeop", 32'(q_eop.size()), 32'd0);
      #2;
      do_reset(1);
      q_eop.delete();
      v[0] = 1; v[1] = 1;
      repeat (20) step();
      check("post_frame", 32'(q_eop.size() >= 1), 32'd1);
      if (q_eop.size() >= 1) check("post_ch", 32'(q_eop[0]), 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         v[0] = ($urandom_range(0, 3) != 0);
         v[1] = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

Frame-level arbiter that shares one FFT datapath between two complex-sample Avalon-ST requesters. Grants whole FFT frames of FFT_LENGTH samples, alternating round-robin. Generates startofpacket/endofpacket from an internal sample counter, since requesters supply none. Tags each frame with its channel and inverse flag. Sits directly upstream of the FFT receive data adapter; its inverse output drives that adapter's direction bit.

## Interface
- INPUT_SYMBOL_WIDTH, 16, width of each of real/imag
- LOG2_FFT_LENGTH, 10, FFT_LENGTH = 2**LOG2_FFT_LENGTH samples per frame
- INVERSE_CH0, 0, inverse flag attached to channel-0 frames
- INVERSE_CH1, 1, inverse flag attached to channel-1 frames
- clock_clk  in  1  single clock, all logic rising-edge
- reset_reset_n  in  1  asynchronous, active-low reset
- asi_ch0_data  in  2*INPUT_SYMBOL_WIDTH  {real, imag}, real in MSBs
- asi_ch0_valid  in  1  channel-0 sample valid
- asi_ch0_ready  out  1  channel-0 sample accepted when valid&ready
- asi_ch1_data / asi_ch1_valid / asi_ch1_ready  same as channel 0
- aso_out_data  out  2*INPUT_SYMBOL_WIDTH  registered sample to FFT path
- aso_out_valid  out  1  output valid
- aso_out_startofpacket  out  1  first sample of frame
- aso_out_endofpacket  out  1  sample FFT_LENGTH-1 of frame
- aso_out_inverse  out  1  inverse flag of current frame
- aso_out_channel  out  1  source channel of current frame
- aso_out_ready  in  1  downstream ready
- busy  out  1  high while a frame is granted (state GRANT)

## Operation
- States: IDLE, GRANT.
- Arbitration happens in IDLE only.
  - If exactly one asi_chX_valid is high, grant X.
  - If both are high, grant the channel not granted last (priority pointer; after reset ch0 wins).
  - If neither is high, stay IDLE.
  - On grant, the next state is GRANT, and grant, sample counter (=0) and inverse/channel tags are registered.
- In GRANT:
  - asi_chX_ready = (grant==X) && (!aso_out_valid || aso_out_ready). The non-granted channel's ready is 0.
  - An accept is valid&ready on the granted channel.
  - Each accept loads the output register with data, startofpacket=(cnt==0) and endofpacket=(cnt==FFT_LENGTH-1), sets aso_out_valid, and increments cnt.
  - An accept with cnt==FFT_LENGTH-1 wraps cnt to 0, flips the priority pointer and returns to IDLE.
- Output register:
  - Holds all fields while aso_out_valid && !aso_out_ready.
  - Clears aso_out_valid when aso_out_ready is high and no new accept occurs that cycle.
- Requester valid dropping mid-frame: the arbiter waits in GRANT with no timeout. The frame is never split or interleaved.
- aso_out_inverse/aso_out_channel are loaded with each sample and are constant within a frame.
- Counter width: LOG2_FFT_LENGTH bits. Wrap occurs naturally at FFT_LENGTH-1.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - state=IDLE, cnt=0, priority=ch0;
  - all outputs 0: both readies, aso_out_data, aso_out_valid, aso_out_startofpacket, aso_out_endofpacket, aso_out_inverse, aso_out_channel, busy.
- Reset mid-frame abandons the frame with no EOP. Downstream FFT shares this reset.
- Arbitration latency: valid seen in IDLE at cycle n gives busy and ready at n+1, so the first accept can occur at n+1.
- Data latency: an accept at cycle n puts the sample on aso_out at n+1.
- Throughput: 1 sample/cycle with aso_out_ready held high. Frames are separated by exactly one IDLE cycle on the input side, so the output shows a 1-cycle valid gap between frames.
- Simultaneous final accept and other channel valid: IDLE still occurs for one cycle, then the other channel is granted (pointer already flipped).
- Backpressure: aso_out_ready low at cycle n with aso_out_valid high drops asi ready combinationally in cycle n. No sample is lost or duplicated.

## Test plan
- Single requester, LOG2_FFT_LENGTH=3, ch0 streams 0x0001_0001..0x0008_0008 with ready high. Required out: 8 samples on consecutive cycles, SOP on the first only, EOP on the 8th only, inverse=0, channel=0. Then busy=0 for 1 cycle.
- Both valid continuously from reset. Required frame order: ch0, ch1, ch0, ch1. Channel-1 frames carry inverse=1. No interleaving inside any frame, and a one-cycle gap between frames.
- aso_out_ready toggled 1,0,0,1 pattern during a frame. Required: the output sequence equals the input sequence exactly, and fields are stable while stalled.
- ch1 drops valid for 5 cycles after its 3rd sample while ch0 is valid. Required: grant stays on ch1, asi_ch0_ready stays 0, and ch1's frame completes with EOP before ch0 is served.
- reset_reset_n pulsed low for 2 cycles after sample 4 of a frame. Required: all outputs 0 asynchronously, no EOP emitted, and the next frame starts with SOP on ch0.
- Final accept of a ch0 frame coincides with ch1 valid and ch0 valid. Required: ch1 granted next, after one IDLE cycle.
